// File: rtl/if_fetch_queue.sv
// Fetch stage: PC, synchronous instruction memory and a decoupled fetch queue.
// Optional halt detection on an all-ones word is enabled by IF_HALT_DETECT_EN.
module if_fetch_queue #(
    parameter int                    BITS_SIZE  = 32,
    parameter int                    SIZE_TOTAL = 256,
    parameter int                    FQ_DEPTH   = 4,
    parameter logic [BITS_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_step,
    input  logic                        i_load_en,
    input  logic [BITS_SIZE-1:0]        i_load_addr,
    input  logic [BITS_SIZE-1:0]        i_load_data,
    input  logic                        i_redirect,
    input  logic [BITS_SIZE-1:0]        i_redirect_pc,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [BITS_SIZE-1:0]        o_instruction,
    output logic [BITS_SIZE-1:0]        o_pc,
    output logic [BITS_SIZE-1:0]        o_pc4,
    output logic [BITS_SIZE-1:0]        o_pc8,
    output logic [$clog2(FQ_DEPTH):0]   o_count,
    output logic                        o_halted
);

    localparam int PW    = $clog2(FQ_DEPTH);
    localparam int CW    = PW + 1;
    localparam int AW    = $clog2(SIZE_TOTAL);
    localparam int WORDS = SIZE_TOTAL / 4;
    localparam logic [BITS_SIZE-1:0] MEM_END = BITS_SIZE'(SIZE_TOTAL);
    localparam logic [BITS_SIZE-1:0] FOUR    = BITS_SIZE'(4);
    localparam logic [BITS_SIZE-1:0] EIGHT   = BITS_SIZE'(8);

    typedef struct packed {
        logic [BITS_SIZE-1:0] instr;
        logic [BITS_SIZE-1:0] pc;
        logic [BITS_SIZE-1:0] pc4;
        logic [BITS_SIZE-1:0] pc8;
    } fq_entry_t;

    logic [BITS_SIZE-1:0] mem [WORDS];
    fq_entry_t            fq_mem [FQ_DEPTH];

    logic [BITS_SIZE-1:0] pc_q, pc_d;
    logic [BITS_SIZE-1:0] fa_q, fa_d;
    logic                 inflight_q, inflight_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    fq_entry_t            last_q, last_d;
    logic [BITS_SIZE-1:0] rdata_q;

    logic                 halt_w;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CW:0]          occ;
    logic                 load_we;
    logic                 rd_in_range;
    fq_entry_t            head;
    fq_entry_t            new_entry;

    assign head    = fq_mem[rd_ptr_q];
    assign o_valid = (count_q != '0);
    assign pop     = o_valid & i_ready & i_step;
    assign push    = i_step & inflight_q & ~i_redirect & ~halt_w;
    // Slot reservation counts the fetch already in flight.
    assign occ     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue   = i_step & ~i_load_en & ~i_redirect & ~halt_w
                   & (occ < (CW+1)'(FQ_DEPTH));

    assign load_we     = i_step & i_load_en & (i_load_addr < MEM_END);
    assign rd_in_range = (pc_q < MEM_END);

    assign new_entry.instr = rdata_q;
    assign new_entry.pc    = fa_q;
    assign new_entry.pc4   = fa_q + FOUR;
    assign new_entry.pc8   = fa_q + EIGHT;

    assign o_instruction = o_valid ? head.instr : last_q.instr;
    assign o_pc          = o_valid ? head.pc    : last_q.pc;
    assign o_pc4         = o_valid ? head.pc4   : last_q.pc4;
    assign o_pc8         = o_valid ? head.pc8   : last_q.pc8;
    assign o_count       = count_q;

    always_ff @(posedge i_clk) begin
        if (load_we) begin
            mem[i_load_addr[AW-1:2]] <= i_load_data;
        end
        if (issue) begin
            rdata_q <= rd_in_range ? mem[pc_q[AW-1:2]] : '0;
        end
        if (push) begin
            fq_mem[wr_ptr_q] <= new_entry;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        fa_d       = fa_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        if (i_step) begin
            if (o_valid && (pop || i_redirect)) begin
                last_d = head;
            end
            if (i_redirect) begin
                pc_d       = i_redirect_pc;
                inflight_d = 1'b0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                count_d    = count_q + CW'(push) - CW'(pop);
                inflight_d = issue;
                if (issue) begin
                    pc_d = pc_q + FOUR;
                    fa_d = pc_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q       <= RESET_PC;
            fa_q       <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            fa_q       <= fa_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
        end
    end

`ifdef IF_HALT_DETECT_EN
    logic halted_q, halted_d;

    // A killed response never sets the flag; a redirect always clears it.
    always_comb begin
        halted_d = halted_q;
        if (i_step) begin
            if (i_redirect) begin
                halted_d = 1'b0;
            end else if (push && (rdata_q == '1)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halt_w = halted_q;
`else
    assign halt_w = 1'b0;
`endif

    assign o_halted = halt_w;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupled fetch queue. Holds the PC, reads a synchronous-read instruction memory (loadable through a debug write port), and buffers fetched instructions with their PC, PC+4 and PC+8 in a FIFO drained by the decode stage over a valid/ready handshake. Control-flow redirects from later stages flush the queue and kill any in-flight fetch. Sits between the loader/debug unit and ID, replacing the single-register fetch path.

## Interface
- BITS_SIZE, 32: data/address width.
- SIZE_TOTAL, 256: instruction memory size in bytes, a multiple of 4; SIZE_TOTAL/4 words.
- FQ_DEPTH, 4: fetch-queue entries, a power of 2, at least 2.
- RESET_PC, 0: PC value after reset.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_step  in  1  global enable; when 0 all state holds, including PC, queue, in-flight flag and halt flag.
- i_load_en  in  1  memory write strobe from the loader.
- i_load_addr  in  BITS_SIZE  byte address of the write; bits [1:0] ignored.
- i_load_data  in  BITS_SIZE  instruction word to write.
- i_redirect  in  1  taken jump, JALR or branch resolved downstream.
- i_redirect_pc  in  BITS_SIZE  new fetch address.
- i_ready  in  1  ID accepts the head entry.
- o_valid  out  1  head entry is valid.
- o_instruction  out  BITS_SIZE  head instruction.
- o_pc, o_pc4, o_pc8  out  BITS_SIZE each  head PC, PC+4 and PC+8, modulo 2^BITS_SIZE.
- o_count  out  clog2(FQ_DEPTH)+1  queue occupancy.
- o_halted  out  1  fetch halted (see Configuration).

## Operation
- Memory: word index is addr[clog2(SIZE_TOTAL)-1:2]. A read whose address is at or above SIZE_TOTAL returns 0x00000000 (NOP).
- Issue condition: i_step, !i_load_en, !i_redirect, !o_halted, and count + inflight − pop < FQ_DEPTH, where pop = o_valid & i_ready & i_step.
- On issue:
  - Memory is read at the PC.
  - inflight is set to 1 and the fetch address is latched.
  - PC <= PC + 4.
- Response: in the cycle after an issue, the data is pushed as {instr, pc, pc+4, pc+8}, unless a redirect occurs in that cycle.
- Push and pop may occur in the same cycle; count is then unchanged.
- Pop: the head is removed when o_valid & i_ready & i_step. Outputs always show the head entry; they hold their last value when the queue is empty.
- Redirect, when i_step is 1:
  - The head handshake in the same cycle still counts as consumed.
  - The queue is emptied and inflight is cleared; the response for the killed fetch is dropped.
  - PC <= i_redirect_pc.
  - The halt flag is cleared.
- Load: when i_load_en & i_step, the word is written. Issue is suppressed, but the queue keeps draining and a pending response is still pushed. A read and a write to the same word in one cycle cannot occur because issue is blocked.
- Precedence, highest first: reset, !i_step hold, redirect, load, normal fetch.

## Timing
- Reset values:
  - PC = RESET_PC; queue empty, count = 0, inflight = 0.
  - o_valid = 0, o_halted = 0.
  - o_instruction = o_pc = o_pc4 = o_pc8 = 0.
- Latency after reset release with i_step=1: issue at edge 1, push at edge 2; o_valid=1 after edge 2. Redirect at edge k gives o_valid=1 after edge k+2.
- Throughput: one instruction per cycle with i_ready held at 1, for any FQ_DEPTH ≥ 2.
- Full: with i_ready=0, count reaches FQ_DEPTH and stays there with inflight=0. No entry is lost or duplicated.
- Pointers wrap modulo FQ_DEPTH. The PC wraps modulo 2^BITS_SIZE.
- Reset asserted mid-operation: all state returns to the reset values immediately, without waiting for a clock edge. Memory contents are not cleared by reset.

## Configuration
- IF_HALT_DETECT_EN defined: when a pushed instruction equals all ones (0xFFFFFFFF), o_halted is set on the same edge. Issue then stops. Queued entries, including the halt word, still drain. Only reset or a redirect clears the flag.
- Not defined: o_halted is tied to 0, and 0xFFFFFFFF is fetched as an ordinary word.

## Test plan
- Sequential fetch: load words 0x11,0x22,0x33 at addresses 0,4,8; release reset with i_ready=1 -> o_valid rises after edge 2; the bench sees (pc,instr) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles, with o_pc8=8 on the first.
- Backpressure, FQ_DEPTH=4: i_ready=0 -> o_count saturates at 4 and PC stops at 16; raising i_ready releases pcs 0,4,8,12,16… in order with no gaps.
- Redirect: i_redirect with i_redirect_pc=0x40 while 3 entries are queued -> o_count=0 next cycle; the next valid entry is pc=0x40, 2 cycles later; no stale pc appears.
- Step/load: i_step=0 for 5 cycles -> all outputs and o_count unchanged. A load to address 0x20 during fetch is readable later at pc 0x20; address 0x100 returns 0.
- Halt (macro on): word 0xFFFFFFFF at address 8 -> pcs 0,4,8 are delivered, then o_halted=1 and no further issue. A redirect to 0 clears o_halted and fetching resumes.
- Async reset with the queue full -> o_valid=0, o_count=0, o_pc=0 before the next clock edge.
